// File: rtl/instruction_fetch_unit.sv
// Instruction issue stage: holds a small program memory and presents one instruction
// per 8-clock frame, in lockstep with the decoder's free-running CLK1..CLK8 sequence.
module instruction_fetch_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [7:0]    LOAD_DATA,
    input  logic          START,
    output logic [2:0]    Opcode,
    output logic [2:0]    Operand_1_address,
    output logic          Operand_2_type,
    output logic          Operand_number,
    output logic [AW-1:0] PC,
    output logic [2:0]    Frame,
    output logic          Running,
    output logic          Halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [7:0]    HLT_WORD  = 8'b111_000_0_0;
    localparam logic [2:0]    HLT_OP    = 3'b111;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    ir_q, ir_d;
    logic [2:0]    frame_q, frame_d;
    logic          last_q, last_d;
    logic          running_q, running_d;
    logic          halted_q, halted_d;
    logic          mem_we;
    logic [7:0]    fetch_word;

    assign fetch_word = mem[pc_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        last_d  = last_q;
        frame_d = frame_q + 3'd1;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                // A load in the same cycle as START wins; START is dropped.
                if (LOAD_EN) begin
                    mem_we = ({1'b0, LOAD_ADDR} < DEPTH_W);
                end else if (START) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    last_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (frame_q == 3'd7) begin
                    if (last_q) begin
                        // Past the final word: issue a synthetic HLT, PC stays put.
                        ir_d    = HLT_WORD;
                        state_d = S_HALTED;
                    end else begin
                        ir_d = fetch_word;
                        if (fetch_word[7:5] == HLT_OP) begin
                            state_d = S_HALTED;
                        end else if (pc_q == LAST_ADDR) begin
                            last_d = 1'b1;
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d == S_RUN);
        halted_d  = (state_d == S_HALTED);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= HLT_WORD;
            frame_q   <= 3'd0;
            last_q    <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            frame_q   <= frame_d;
            last_q    <= last_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    // Program memory survives reset so a fresh START replays the same program.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    assign Opcode            = ir_q[7:5];
    assign Operand_1_address = ir_q[4:2];
    assign Operand_2_type    = ir_q[1];
    assign Operand_number    = ir_q[0];
    assign PC                = pc_q;
    assign Frame             = frame_q;
    assign Running           = running_q;
    assign Halted            = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: a 16-word and a 4-word instance
// checked against a program-level model of which words are issued in which frame.
module tb_instruction_fetch_unit;

    logic       CLK;
    logic       RESET;
    logic       ld_en1, ld_en2, start1, start2;
    logic [3:0] ld_addr1;
    logic [1:0] ld_addr2;
    logic [7:0] ld_data;

    logic [2:0] opc1, op1a1, opc2, op1a2;
    logic       op2t1, opn1, op2t2, opn2;
    logic [3:0] pc1;
    logic [1:0] pc2;
    logic [2:0] frame1, frame2;
    logic       run1, run2, hlt1, hlt2;

    instruction_fetch_unit #(.DEPTH(16), .AW(4)) dut16 (
        .CLK(CLK), .RESET(RESET), .LOAD_EN(ld_en1), .LOAD_ADDR(ld_addr1),
        .LOAD_DATA(ld_data), .START(start1), .Opcode(opc1),
        .Operand_1_address(op1a1), .Operand_2_type(op2t1), .Operand_number(opn1),
        .PC(pc1), .Frame(frame1), .Running(run1), .Halted(hlt1)
    );

    instruction_fetch_unit #(.DEPTH(4), .AW(2)) dut4 (
        .CLK(CLK), .RESET(RESET), .LOAD_EN(ld_en2), .LOAD_ADDR(ld_addr2),
        .LOAD_DATA(ld_data), .START(start2), .Opcode(opc2),
        .Operand_1_address(op1a2), .Operand_2_type(op2t2), .Operand_number(opn2),
        .PC(pc2), .Frame(frame2), .Running(run2), .Halted(hlt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         sel_g  = 0;
    int         m_frame = 0;
    logic [7:0] m_ir  [2];
    logic [7:0] mem_m [2][16];

    logic [7:0] s_word;
    logic [3:0] s_pc;
    logic [2:0] s_frame;
    logic       s_run, s_hlt;

    always_comb begin
        s_word  = (sel_g == 1) ? {opc2, op1a2, op2t2, opn2} : {opc1, op1a1, op2t1, opn1};
        s_pc    = (sel_g == 1) ? {2'b00, pc2} : pc1;
        s_frame = (sel_g == 1) ? frame2 : frame1;
        s_run   = (sel_g == 1) ? run2 : run1;
        s_hlt   = (sel_g == 1) ? hlt2 : hlt1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        m_frame = (m_frame + 1) % 8;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        m_frame = 0;
        m_ir[0] = 8'hE0;
        m_ir[1] = 8'hE0;
        for (int s = 0; s < 2; s++) begin
            sel_g = s;
            #0;
            chk("rst_word", s_word, 8'hE0);
            chk("rst_pc", s_pc, 0);
            chk("rst_frame", s_frame, 0);
            chk("rst_run", s_run, 0);
            chk("rst_hlt", s_hlt, 0);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic load(input int sel, input int addr, input logic [7:0] data, input bit with_start);
        ld_addr1 = 4'(addr);
        ld_addr2 = 2'(addr);
        ld_data  = data;
        if (sel == 1) begin
            ld_en2 = 1'b1; start2 = with_start;
        end else begin
            ld_en1 = 1'b1; start1 = with_start;
        end
        tick();
        ld_en1 = 1'b0; ld_en2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mem_m[sel][addr] = data;
    endtask

    // Start the selected DUT at a given frame and follow the program the model predicts.
    task automatic run_check(input int sel, input int start_frame, input int abort_issue, input bit ld_in_run);
        int depth, i, n, pf, exp_pc;
        bit done, fetched, hlt;
        logic [7:0] w;
        depth = (sel == 1) ? 4 : 16;
        sel_g = sel;
        n = 0;
        while (m_frame != start_frame && n < 8) begin
            tick(); n++;
        end
        if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0; start2 = 1'b0;
        chk("start_run", s_run, 1);
        chk("start_hlt", s_hlt, 0);
        chk("start_pc", s_pc, 0);
        exp_pc = 0;
        i = 0;
        done = 0;
        while (!done) begin
            fetched = 0;
            n = 0;
            while (!fetched && n < 9) begin
                pf = m_frame;
                tick(); n++;
                ld_en1 = 1'b0; ld_en2 = 1'b0;
                if (pf == 7) fetched = 1;
                else chk("stable", s_word, m_ir[sel]);
            end
            if (!fetched) begin
                chk("fetch_timeout", 0, 1);
                return;
            end
            w = (i >= depth) ? 8'hE0 : mem_m[sel][i];
            hlt = (w[7:5] == 3'b111);
            if (i >= depth)      exp_pc = depth - 1;
            else if (hlt)        exp_pc = i;
            else if (i == depth - 1) exp_pc = depth - 1;
            else                 exp_pc = i + 1;
            m_ir[sel] = w;
            chk("issue_word", s_word, w);
            chk("issue_pc", s_pc, exp_pc);
            chk("issue_frame", s_frame, 0);
            chk("issue_run", s_run, !hlt);
            chk("issue_hlt", s_hlt, hlt);
            if (ld_in_run && i == 0) begin
                ld_addr1 = 4'd0; ld_addr2 = 2'd0;
                ld_data  = ~mem_m[sel][0];
                if (sel == 1) ld_en2 = 1'b1; else ld_en1 = 1'b1;
            end
            if (abort_issue == i + 1) begin
                for (int k = 0; k < 4; k++) begin
                    tick();
                    ld_en1 = 1'b0; ld_en2 = 1'b0;
                    chk("pre_abort", s_word, m_ir[sel]);
                end
                do_reset();
                return;
            end
            i++;
            done = hlt;
        end
        for (int k = 0; k < 10; k++) tick();
        chk("post_hlt", s_hlt, 1);
        chk("post_run", s_run, 0);
        chk("post_word", s_word, m_ir[sel]);
        chk("post_pc", s_pc, exp_pc);
    endtask

    task automatic rand_prog(input int sel);
        int depth, hidx;
        logic [7:0] w;
        depth = (sel == 1) ? 4 : 16;
        hidx = ($urandom_range(0, 2) != 0) ? $urandom_range(0, depth - 1) : -1;
        for (int j = 0; j < depth; j++) begin
            if (j == hidx) w = {3'b111, 5'($urandom())};
            else           w = {3'($urandom_range(0, 6)), 5'($urandom())};
            load(sel, j, w, 1'b0);
        end
    endtask

    initial begin
        RESET = 1'b1;
        ld_en1 = 1'b0; ld_en2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        ld_addr1 = '0; ld_addr2 = '0; ld_data = '0;
        m_ir[0] = 8'hE0; m_ir[1] = 8'hE0;
        do_reset();

        sel_g = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_frame", s_frame, m_frame);
            chk("idle_word", s_word, 8'hE0);
            chk("idle_run", s_run, 0);
            chk("idle_pc", s_pc, 0);
        end

        load(0, 0, 8'b001_011_0_1, 1'b1);
        chk("ld_start_run", s_run, 0);
        chk("ld_start_hlt", s_hlt, 0);
        load(0, 1, 8'b000_010_1_0, 1'b0);
        load(0, 2, 8'hE0, 1'b0);
        run_check(0, 3, 0, 1'b0);

        run_check(0, 5, 0, 1'b1);
        run_check(0, 0, 0, 1'b0);

        run_check(0, 1, 2, 1'b0);
        chk("abort_run", s_run, 0);
        run_check(0, 6, 0, 1'b0);

        for (int j = 0; j < 4; j++) load(1, j, {3'(j), 5'(j * 5 + 1)}, 1'b0);
        run_check(1, 2, 0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            rand_prog(it % 2);
            run_check(it % 2, $urandom_range(0, 7), 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Instruction-issue end of the decoder interface: holds a small program memory, keeps a program counter, and presents one instruction per 8-clock execution frame on the Opcode / Operand fields the instruction decoder samples.
- Runs a free-running 3-bit frame counter from reset, in lockstep with the decoder's internal CLK1..CLK8 sequence, so fields are stable whenever the decoder samples them.
- Stops issuing on HLT.

Parameters:
- DEPTH, 16, number of 8-bit program words.
- AW, 4, program counter / load address width; must satisfy 2^AW >= DEPTH.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- LOAD_EN  input  1  write LOAD_DATA into program memory at LOAD_ADDR this cycle.
- LOAD_ADDR  input  AW  program memory write address.
- LOAD_DATA  input  8  instruction word: [7:5] opcode, [4:2] operand 1 address, [1] operand 2 type, [0] operand number.
- START  input  1  single-cycle pulse; begins execution from address 0.
- Opcode  output  3  current instruction opcode, to the decoder.
- Operand_1_address  output  3  current operand 1 address, to the decoder.
- Operand_2_type  output  1  current operand 2 type, to the decoder.
- Operand_number  output  1  current operand number, to the decoder.
- PC  output  AW  address of the next word to fetch.
- Frame  output  3  frame counter value, 0..7.
- Running  output  1  high in state RUN.
- Halted  output  1  high in state HALTED.

Behaviour:
- Reset (async, RESET=0):
  - Frame=0, PC=0, state=IDLE.
  - Instruction register = 8'b111_000_0_0, so Opcode=3'b111 (HLT) and all other fields 0.
  - Running=0, Halted=0.
  - Program memory contents are not affected by reset.
- Frame counter:
  - Increments every edge after reset in every state; wraps 7->0.
  - It is never gated, so alignment with the decoder is fixed by the shared reset release.
- States: IDLE, RUN, HALTED.
  - IDLE:
    - LOAD_EN=1 writes memory.
    - START=1 with LOAD_EN=0 -> RUN, PC<=0.
    - START and LOAD_EN together: the load is performed and START is ignored.
    - Instruction register holds HLT.
  - RUN:
    - On each edge where Frame==7 (the edge entering Frame 0), load the instruction register from mem[PC] and set PC<=PC+1.
    - The new fields are therefore valid from Frame 0 through Frame 7, and stable at the decoder's opcode sample (Frame 1) and address samples (Frames 3, 5, 6).
    - LOAD_EN and START are ignored in RUN.
    - If the word being fetched has opcode 3'b111, it is still loaded, PC is not incremented, and the state goes to HALTED on the same edge.
    - If PC==DEPTH-1 at a fetch, fetch that word normally. At the next fetch edge, inject HLT (8'b111_000_0_0) instead of reading memory and go to HALTED. PC stays at DEPTH-1; it never wraps.
    - START arriving mid-frame before the first fetch: the first fetch waits for the next Frame==7 edge, giving 0..7 cycles of start latency.
  - HALTED:
    - Instruction register holds its HLT word. Halted=1.
    - LOAD_EN is accepted.
    - START (with LOAD_EN=0) -> RUN, PC<=0.
- Outputs are direct register outputs; no combinational path from inputs.
- Reset mid-frame or mid-run: immediate return to IDLE with reset values. Memory is retained, so a new START re-executes the same program.
- Memory is write-synchronous with an asynchronous read at PC. Writes to addresses >= DEPTH are ignored.

Test Plan:
- Reset/idle: assert RESET=0 mid-cycle, release -> Opcode=3'b111, PC=0, Frame counts 0..7 and wraps, Running=0, Halted=0; START never pulsed -> fields stay HLT indefinitely.
- Load and run: load mem[0]=8'b001_011_0_1 (ADD r3), mem[1]=8'b000_010_1_0 (MOV r2), mem[2]=8'hE0. Pulse START at Frame=3.
  - Edge entering Frame 0 -> Opcode=001, Operand_1_address=011, Operand_number=1, PC=1, held for 8 cycles.
  - Next frame -> MOV fields, PC=2.
  - Next frame -> Opcode=111, Halted=1, Running=0, PC=2.
- Stability: during RUN, check that Opcode and Operand_1_address never change except on Frame 7->0 edges.
- End of memory: DEPTH=4, load four non-HLT words, START -> four frames of issue, then HLT injected in the fifth frame with PC=3, Halted=1.
- Priority/ignore: in IDLE, pulse LOAD_EN and START together -> word written, state stays IDLE. In RUN, pulse LOAD_EN to addr 0 -> mem[0] unchanged (verified after halt and restart).
- Reset mid-run: RESET=0 at Frame 4 of the second instruction -> immediate HLT outputs, PC=0, IDLE. START again -> program re-executes from mem[0] with the original contents.
